// File: rtl/fetch_decode.sv
//------------------------------------------------------------------------------
// Module   : fetch_decode
// Purpose  : Fetch/decode sequencer. Resolves JSR/RET/HALT through the PC
//            controls and hands other instructions to execute over valid/ready.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_decode #(
    parameter logic [10:0] BOOT_DEFAULT = 11'h000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] boot_addr,
    input  logic        boot_addr_sel,
    input  logic [10:0] pc,
    output logic [10:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        preload,
    output logic [10:0] preload_addr,
    output logic        jsr,
    output logic        ret,
    output logic [9:0]  relative_addr,
    output logic [15:0] instr,
    output logic [10:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] C_OP_JSR  = 4'hC;
    localparam logic [3:0] C_OP_RET  = 4'hD;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  w_opcode;

    assign w_opcode  = instr[15:12];
    assign imem_addr = pc;

    // The PC has no enable: every cycle that is not a step, jump or return
    // preloads the PC with its own value.
    always_comb begin
        w_next_state  = r_state;
        preload       = 1'b0;
        preload_addr  = pc;
        jsr           = 1'b0;
        ret           = 1'b0;
        relative_addr = 10'h000;
        instr_valid   = 1'b0;
        case (r_state)
            S_BOOT: begin
                preload      = 1'b1;
                preload_addr = boot_addr_sel ? boot_addr : BOOT_DEFAULT;
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                preload      = 1'b1;
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                preload      = 1'b1;
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                case (w_opcode)
                    C_OP_JSR: begin
                        jsr           = 1'b1;
                        relative_addr = instr[9:0];
                        w_next_state  = S_FETCH;
                    end
                    C_OP_RET: begin
                        ret          = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    C_OP_HALT: begin
                        preload      = 1'b1;
                        w_next_state = S_HALTED;
                    end
                    default: begin
                        instr_valid = 1'b1;
                        if (instr_ready) begin
                            w_next_state = S_FETCH;
                        end else begin
                            preload = 1'b1;
                        end
                    end
                endcase
            end
            S_HALTED: begin
                preload = 1'b1;
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_BOOT;
            instr    <= 16'h0000;
            instr_pc <= 11'h000;
            halted   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            halted  <= (w_next_state == S_HALTED);
            if (r_state == S_LOAD) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_decode
// Purpose  : Directed bench for fetch_decode with a PC and program memory model
//            and a scoreboard of expected execute transfers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_decode;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] boot_addr;
    logic        boot_addr_sel;
    logic [10:0] pc;
    logic [10:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        preload;
    logic [10:0] preload_addr;
    logic        jsr;
    logic        ret;
    logic [9:0]  relative_addr;
    logic [15:0] instr;
    logic [10:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_xfer_cycle = 0;
    int xfer_count = 0;

    logic [15:0] mem [0:2047];
    logic [10:0] ret_slot;
    logic [26:0] exp_q [$];

    fetch_decode #(.BOOT_DEFAULT(11'h000)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .boot_addr     (boot_addr),
        .boot_addr_sel (boot_addr_sel),
        .pc            (pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .preload       (preload),
        .preload_addr  (preload_addr),
        .jsr           (jsr),
        .ret           (ret),
        .relative_addr (relative_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    // Program counter and synchronous program memory models.
    always @(posedge clock) begin
        if (!reset_n) begin
            pc <= 11'h000;
        end else if (preload) begin
            pc <= preload_addr;
        end else if (jsr) begin
            ret_slot <= pc;
            pc       <= pc + {1'b0, relative_addr};
        end else if (ret) begin
            pc <= ret_slot + 11'd1;
        end else begin
            pc <= pc + 11'd1;
        end
        imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer scoreboard and per-cycle control exclusivity.
    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (reset_n) begin
            check("ctrl_onehot", 32'($countones({preload, jsr, ret}) <= 1), 32'd1);
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", {5'd0, instr, instr_pc}, 32'hFFFF_FFFF);
                end else begin
                    check("xfer", {5'd0, instr, instr_pc}, {5'd0, exp_q.pop_front()});
                end
                if (xfer_count == 1) begin
                    check("xfer_interval", 32'(cycle - last_xfer_cycle), 32'd3);
                end
                xfer_count      <= xfer_count + 1;
                last_xfer_cycle <= cycle;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[11'h000] = 16'h1234;
        mem[11'h001] = 16'h2345;
        mem[11'h002] = 16'h3456;
        mem[11'h003] = 16'hF000;
        mem[11'h010] = 16'hC005;
        mem[11'h015] = 16'hD000;
        mem[11'h011] = 16'h4111;
        mem[11'h012] = 16'hF000;
        mem[11'h7F0] = 16'hC3FF;
        mem[11'h3EF] = 16'hF000;

        reset_n       = 1'b0;
        boot_addr     = 11'h000;
        boot_addr_sel = 1'b0;
        instr_ready   = 1'b1;
        exp_q.push_back({16'h1234, 11'h000});
        exp_q.push_back({16'h2345, 11'h001});
        exp_q.push_back({16'h3456, 11'h002});

        // Reset then boot
        step();
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_valid0", 32'(instr_valid), 32'h0);
        check("rst_jsr", 32'(jsr), 32'h0);
        check("rst_ret", 32'(ret), 32'h0);
        check("rst_rel", 32'(relative_addr), 32'h0);
        step();
        check("rst_valid1", 32'(instr_valid), 32'h0);
        step();
        check("rst_valid2", 32'(instr_valid), 32'h0);
        reset_n = 1'b1;
        #1;
        check("boot_preload", 32'(preload), 32'h1);
        check("boot_addr", 32'(preload_addr), 32'h000);

        // Straight-line code
        step();
        check("fetch0_pc", 32'(pc), 32'h000);
        check("fetch0_imem", 32'(imem_addr), 32'h000);
        check("fetch0_valid", 32'(instr_valid), 32'h0);
        step();
        check("load0_pc", 32'(pc), 32'h000);
        step();
        check("issue0_valid", 32'(instr_valid), 32'h1);
        check("issue0_instr", 32'(instr), 32'h1234);
        step();
        check("fetch1_pc", 32'(pc), 32'h001);
        step();
        step();
        check("issue1_instr", 32'(instr), 32'h2345);
        check("issue1_pc", 32'(instr_pc), 32'h001);
        step();
        step();
        instr_ready = 1'b0;

        // Stall for five ISSUE cycles
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_instr", 32'(instr), 32'h3456);
            check("stall_pc", 32'(pc), 32'h002);
            if (i < 4) step();
        end
        instr_ready = 1'b1;
        step();
        check("post_stall_pc", 32'(pc), 32'h003);

        // HALT at 0x003
        step();
        step();
        check("halt_issue_valid", 32'(instr_valid), 32'h0);
        check("halt_issue_preload", 32'(preload), 32'h1);
        step();
        check("halted", 32'(halted), 32'h1);
        step();
        step();
        check("halted_pc", 32'(pc), 32'h003);
        check("halted_hold", 32'(halted), 32'h1);

        // Reset pulse while halted, reboot at 0x010 for JSR/RET
        reset_n = 1'b0;
        step();
        check("pulse_halted", 32'(halted), 32'h0);
        reset_n       = 1'b1;
        boot_addr_sel = 1'b1;
        boot_addr     = 11'h010;
        #1;
        check("reboot_addr", 32'(preload_addr), 32'h010);
        step();
        check("reboot_pc", 32'(pc), 32'h010);
        step();
        step();
        check("jsr_pulse", 32'(jsr), 32'h1);
        check("jsr_rel", 32'(relative_addr), 32'h005);
        check("jsr_preload", 32'(preload), 32'h0);
        check("jsr_valid", 32'(instr_valid), 32'h0);
        step();
        check("jsr_once", 32'(jsr), 32'h0);
        check("jsr_target", 32'(pc), 32'h015);
        step();
        step();
        check("ret_pulse", 32'(ret), 32'h1);
        check("ret_preload", 32'(preload), 32'h0);
        check("ret_valid", 32'(instr_valid), 32'h0);
        exp_q.push_back({16'h4111, 11'h011});
        step();
        check("ret_once", 32'(ret), 32'h0);
        check("ret_target", 32'(pc), 32'h011);
        step();
        step();
        check("after_ret_valid", 32'(instr_valid), 32'h1);
        step();
        step();
        step();
        step();
        check("halt2", 32'(halted), 32'h1);
        check("halt2_pc", 32'(pc), 32'h012);

        // Wrap-around JSR from 0x7F0
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        boot_addr = 11'h7F0;
        step();
        check("wrap_boot_pc", 32'(pc), 32'h7F0);
        step();
        step();
        check("wrap_jsr", 32'(jsr), 32'h1);
        check("wrap_rel", 32'(relative_addr), 32'h3FF);
        step();
        check("wrap_target", 32'(pc), 32'h3EF);
        step();
        step();
        step();
        check("wrap_halted", 32'(halted), 32'h1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("xfer_total", 32'(xfer_count), 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode sequencer between the program counter and the execute stage. It presents the PC value to the synchronous program memory, captures the returned 16-bit word, and resolves control flow locally: JSR, RET and HALT are executed by driving the PC's `preload`/`jsr`/`ret` controls. All other instructions go to execute over a valid/ready handshake. The PC has no enable, so this block holds it during fetch and stall cycles by preloading its current value.

## Interface
Parameters:
- `BOOT_DEFAULT`, 11'h000: value of `preload_addr` in BOOT when `boot_addr_sel` = 0.

Ports:
- `clock`  in  1  rising-edge clock, shared with the PC.
- `reset_n`  in  1  synchronous, active-low reset.
- `boot_addr`  in  11  alternate start address.
- `boot_addr_sel`  in  1  1: boot from `boot_addr`; 0: boot from `BOOT_DEFAULT`.
- `pc`  in  11  current PC output.
- `imem_addr`  out  11  program memory address, equal to `pc`.
- `imem_rdata`  in  16  program memory data, valid the cycle after the address is sampled.
- `preload`  out  1  to PC.
- `preload_addr`  out  11  to PC.
- `jsr`  out  1  to PC.
- `ret`  out  1  to PC.
- `relative_addr`  out  10  to PC; JSR offset.
- `instr`  out  16  registered instruction word to execute.
- `instr_pc`  out  11  address of `instr`.
- `instr_valid`  out  1  `instr` is offered to execute.
- `instr_ready`  in  1  execute accepts `instr`.
- `halted`  out  1  HALT reached; fetch stopped.

## Operation
- Opcode is `instr[15:12]`:
  - 4'hC = JSR, offset `instr[9:0]`.
  - 4'hD = RET.
  - 4'hF = HALT.
  - Anything else is an execute instruction.
- The state register resets to BOOT. States:
  - BOOT:
    - Drives `preload`=1 and `preload_addr` = selected boot address.
    - Next state FETCH.
  - FETCH:
    - Drives `imem_addr` = `pc`, `preload`=1, `preload_addr` = `pc` (PC held).
    - Next state LOAD.
  - LOAD:
    - PC held as in FETCH.
    - `instr` <= `imem_rdata` and `instr_pc` <= `pc` at the closing edge.
    - Next state ISSUE.
  - ISSUE, decoded from `instr`:
    - Execute instruction:
      - Drives `instr_valid`=1.
      - While `instr_ready`=0: PC held, stay in ISSUE.
      - On `instr_ready`=1: drives `preload`=0, `jsr`=0, `ret`=0, so the PC steps to `pc`+1 at the same edge. Next state FETCH.
    - JSR:
      - Drives `jsr`=1, `relative_addr` = `instr[9:0]`, `preload`=0, `instr_valid`=0 for exactly one cycle.
      - Next state FETCH.
    - RET:
      - Drives `ret`=1, `preload`=0, `instr_valid`=0 for one cycle.
      - Next state FETCH.
    - HALT:
      - PC held, `instr_valid`=0.
      - Next state HALTED.
  - HALTED:
    - PC held; `halted`=1.
    - Exit only through reset.
- At most one of `preload`, `jsr`, `ret` is 1 in any cycle.
- Arithmetic is done in the PC:
  - `relative_addr` is unsigned and zero-extended, giving a forward-only jump.
  - Targets wrap modulo 2048.
  - This block performs no address arithmetic.
- Single return slot:
  - A nested JSR overwrites the saved return address.
  - RET without a prior JSR returns to the stale slot + 1.
  - Neither case is detected or flagged.

## Timing
- State, `instr`, `instr_pc` and `halted` are registers. `preload`, `preload_addr`, `jsr`, `ret`, `relative_addr` and `instr_valid` are decoded combinationally from the state and `instr`.
- Reset:
  - While `reset_n`=0 at an edge, the next state is BOOT.
  - `instr` = 16'h0000, `instr_pc` = 11'h000, `halted`=0.
  - `instr_valid`=0, `jsr`=0, `ret`=0, `relative_addr` = 10'h000.
- Reset asserted mid-operation (any state, including ISSUE with `instr_valid`=1):
  - The offer is withdrawn at the next edge with no handshake.
  - BOOT then re-preloads the PC.
- Throughput and latency:
  - Execute instruction: 3 cycles (FETCH, LOAD, ISSUE) plus any ready stall.
  - JSR and RET: 3 cycles each, producing no execute handshake.
  - First FETCH occurs 1 cycle after reset release (BOOT).
- Handshake rules:
  - Transfer happens on an edge where `instr_valid` and `instr_ready` are both 1.
  - Once raised, `instr_valid` stays 1 and `instr`/`instr_pc` stay stable until the transfer.
  - `instr_ready` is ignored outside ISSUE.
- `imem_rdata` is sampled only at the LOAD edge.

## Test plan
- Reset then boot:
  - Stimulus: `reset_n`=0 for 3 cycles, then release with `boot_addr_sel`=0.
  - Required: cycle after release shows `preload`=1, `preload_addr` = 11'h000; next FETCH sees `pc`=0; `instr_valid`=0 throughout reset.
- Straight-line code:
  - Stimulus: memory holds 16'h1234 and 16'h2345 at 0x000 and 0x001; `instr_ready` tied 1.
  - Required: `instr` = 16'h1234 with `instr_pc`=0, then 16'h2345 with `instr_pc`=1, one transfer every 3 cycles.
- Stall:
  - Stimulus: `instr_ready`=0 for 5 ISSUE cycles.
  - Required: `instr_valid`, `instr` and `pc` remain constant for all 5 cycles; PC increments only at the transfer edge.
- JSR and RET:
  - Stimulus: word 16'hC005 at 0x010, 16'hD000 at 0x015.
  - Required: one-cycle `jsr`=1 with `relative_addr`=5; next fetch at 0x015; one-cycle `ret`; next fetch at 0x011; no execute handshake for either.
- Wrap-around:
  - Stimulus: JSR 16'hC3FF at 0x7F0.
  - Required: next fetch at 0x3EF.
- HALT and reset:
  - Stimulus: 16'hF000 at 0x003, later `reset_n` pulsed low during HALTED.
  - Required: `halted`=1 and `pc` frozen at 3; after the pulse, `halted`=0 and fetch restarts at the boot address.
